// File: rtl/fp32_mul_round_pack.sv
// -----------------------------------------------------------------------------
// fp32_mul_round_pack
//   Back end of the FP32 multiplier. Takes the 24x24 significand product
//   (hidden bits included) plus operand sign/exponent/class information,
//   normalises, rounds to nearest-even, handles specials and flush-to-zero,
//   and packs the IEEE-754 single result. Two-stage elastic pipeline.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake
//   sign_a, sign_b       operand signs
//   exp_a, exp_b         biased operand exponents
//   man_nz_a, man_nz_b   operand fraction field non-zero (NaN vs inf)
//   prod[47:0]           unsigned product {1,frac_a} x {1,frac_b}
//   out_valid/out_ready  downstream handshake
//   result[31:0]         packed FP32 result
//   flags[3:0]           {invalid, overflow, underflow, inexact}
// -----------------------------------------------------------------------------
module fp32_mul_round_pack #(
  parameter int          BIAS = 127,
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic        man_nz_a,
  input  logic        man_nz_b,
  input  logic [47:0] prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_adv1;   // stage 2 can take a new entry this cycle

  assign w_adv1    = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_adv1;
  assign out_valid = r_s2_valid;

  // ---------------------------------------------------------------------------
  // Stage 1: exponent sum, normalisation, operand classification
  // ---------------------------------------------------------------------------
  logic signed [9:0] w_e_sum;
  logic signed [9:0] w_e1;
  logic [22:0]       w_mant1;
  logic              w_g1;
  logic              w_s1;
  logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;

  // 10-bit signed covers the full range -127 .. 384 after normalise/round.
  assign w_e_sum = $signed({2'b00, exp_a} + {2'b00, exp_b} - 10'(BIAS));
  assign w_e1    = w_e_sum + $signed({9'd0, prod[47]});

  // Product is in [1,4): bit 47 set means the binary point moves one place.
  assign w_mant1 = prod[47] ? prod[46:24] : prod[45:23];
  assign w_g1    = prod[47] ? prod[23]    : prod[22];
  assign w_s1    = prod[47] ? (|prod[22:0]) : (|prod[21:0]);

  assign w_nan_a  = (exp_a == 8'hFF) &  man_nz_a;
  assign w_nan_b  = (exp_b == 8'hFF) &  man_nz_b;
  assign w_inf_a  = (exp_a == 8'hFF) & ~man_nz_a;
  assign w_inf_b  = (exp_b == 8'hFF) & ~man_nz_b;
  // Denormal inputs are treated as zero.
  assign w_zero_a = (exp_a == 8'h00);
  assign w_zero_b = (exp_b == 8'h00);

  logic signed [9:0] r_s1_e;
  logic [22:0]       r_s1_mant;
  logic              r_s1_g, r_s1_s, r_s1_sign;
  logic              r_s1_nan, r_s1_inf, r_s1_zero;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
    end
  end

  // NOTE: the stage payload is deliberately left out of reset; it is only
  // ever observed when its valid bit is set, which is reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_s1_e    <= w_e1;
      r_s1_mant <= w_mant1;
      r_s1_g    <= w_g1;
      r_s1_s    <= w_s1;
      r_s1_sign <= sign_a ^ sign_b;
      r_s1_nan  <= w_nan_a | w_nan_b;
      r_s1_inf  <= w_inf_a | w_inf_b;
      r_s1_zero <= w_zero_a | w_zero_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: round to nearest-even, special-case priority, pack
  // ---------------------------------------------------------------------------
  logic              w_rnd_up;
  logic [23:0]       w_mant_inc;
  logic signed [9:0] w_e_r;
  logic [31:0]       w_result;
  logic [3:0]        w_flags;

  assign w_rnd_up   = r_s1_g & (r_s1_s | r_s1_mant[0]);
  // Carry out of the 23-bit fraction leaves it at zero and bumps the exponent.
  assign w_mant_inc = {1'b0, r_s1_mant} + {23'd0, w_rnd_up};
  assign w_e_r      = r_s1_e + $signed({9'd0, w_mant_inc[23]});

  // NOTE: every output of this block gets a default first, so no path
  // through the priority chain can infer a latch.
  always_comb begin
    w_result = {r_s1_sign, w_e_r[7:0], w_mant_inc[22:0]};
    w_flags  = {3'b000, r_s1_g | r_s1_s};
    if (r_s1_nan || (r_s1_inf && r_s1_zero)) begin
      w_result = QNAN;
      w_flags  = 4'b1000;
    end else if (r_s1_inf) begin
      w_result = {r_s1_sign, 8'hFF, 23'd0};
      w_flags  = 4'b0000;
    end else if (r_s1_zero) begin
      w_result = {r_s1_sign, 31'd0};
      w_flags  = 4'b0000;
    end else if (w_e_r >= 10'sd255) begin
      w_result = {r_s1_sign, 8'hFF, 23'd0};
      w_flags  = 4'b0101;
    end else if (w_e_r <= 10'sd0) begin
      w_result = {r_s1_sign, 31'd0};
      w_flags  = 4'b0011;
    end
  end

  logic [31:0] r_result;
  logic [3:0]  r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= 32'd0;
      r_flags    <= 4'd0;
    end else if (w_adv1) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_result;
        r_flags  <= w_flags;
      end
    end
  end

  assign result = r_result;
  assign flags  = r_flags;

endmodule

// File: doc/fp32_mul_round_pack.md
Name: fp32_mul_round_pack

Overview:
- Downstream stage of the FP32 multiplier, fed by the 24x24 significand product (hidden bits included) and the operands' sign and exponent fields.
- Normalises the 48-bit product, rounds to nearest-even, and forms the biased result exponent.
- Handles zero, inf, NaN, overflow and underflow (flush-to-zero), and packs the IEEE-754 single result.
- Two-stage elastic pipeline with valid/ready on both sides, placed between the mantissa-product stage and the result consumer.

Parameters:
- BIAS, 127, exponent bias applied when summing the biased exponents.
- QNAN, 32'h7FC00000, canonical quiet NaN emitted on invalid or NaN results.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream operand/product presented.
- in_ready  output  1  stage can accept this cycle.
- sign_a, sign_b  input  1 each  operand signs.
- exp_a, exp_b  input  8 each  biased operand exponents.
- man_nz_a, man_nz_b  input  1 each  operand fraction field non-zero; used for NaN detection.
- prod  input  48  unsigned product of {1,frac_a} x {1,frac_b}.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  32  packed FP32 result.
- flags  output  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, result=0, flags=0, in_ready=1.
- Handshakes:
  - Transfer occurs when valid & ready in the same cycle.
  - in_ready = ~s1_valid | adv1, where adv1 = ~s2_valid | out_ready.
  - result and flags hold stable while out_valid & ~out_ready.
  - Latency: 2 cycles from input accept to out_valid. Throughput: 1 per cycle with no bubbles while out_ready=1.
- Stage 1 (normalise), captured on accept:
  - e = exp_a + exp_b - BIAS, computed as 10-bit signed.
  - If prod[47]: mant = prod[46:24], g = prod[23], s = |prod[22:0], e = e + 1.
  - Else: mant = prod[45:23], g = prod[22], s = |prod[21:0].
  - Class bits registered alongside: nan_a/b (exp=255 & man_nz), inf_a/b (exp=255 & ~man_nz), zero_a/b (exp=0; denormal inputs are treated as zero). sign = sign_a ^ sign_b.
- Stage 2 (round/pack), captured when s1_valid & adv1:
  - Round up when g & (s | mant[0]). Carry out of mant gives mant=0 and e = e + 1.
  - inexact = g | s on finite, non-flushed results.
- Priority for the final result (highest first):
  1. Any NaN, or inf x zero: result=QNAN, invalid=1.
  2. Either operand inf: result={sign, 8'hFF, 23'b0}.
  3. Either operand zero: result={sign, 31'b0}.
  4. Rounded e >= 255: result={sign, 8'hFF, 0}, overflow=1, inexact=1.
  5. Rounded e <= 0: result={sign, 31'b0}, underflow=1, inexact=1 (flush-to-zero; no denormal output).
  6. Otherwise: result={sign, e[7:0], mant}.
- Flags are per-result and not sticky.
- Simultaneous events:
  - Accept into s1 while s1 drains to s2 in the same cycle is legal.
  - Output pop and s2 refill in the same cycle is legal.
  - No drop or duplication under any out_ready pattern.
- Reset asserted mid-operation: all in-flight entries are discarded and out_valid falls immediately (asynchronous).

Test Plan:
- 1.5x1.5: exp 127/127, prod=48'h900000000000, out_ready=1 -> 2 cycles later result=32'h40100000, flags=0.
- RNE: exp 127/127, prod=48'h400000C00000 -> 32'h3F800002, inexact=1. prod=48'h400000400000 (tie, even LSB) -> 32'h3F800000, inexact=1.
- Overflow/underflow: exp 254/254, prod=48'h400000000000 -> 32'h7F800000, overflow=1. exp 1/1 -> 32'h00000000, underflow=1, sign preserved when sign_a^sign_b=1.
- Specials: inf x zero (exp_a=255, man_nz_a=0, exp_b=0) -> 32'h7FC00000, invalid=1. NaN x 2.0 -> QNAN, invalid=1. -inf x 3.0 -> 32'hFF800000.
- Backpressure: stream 4 back-to-back vectors, hold out_ready=0 for 3 cycles -> in_ready=0 once s1 and s2 are full, result held stable; on release all 4 results arrive in order, none lost or duplicated.
- Reset mid-stream: drop rst_n with 2 entries in flight -> out_valid=0 immediately; after release, in_ready=1 and the first new vector completes in 2 cycles.
